// File: rtl/fu_wb_arb_pkg.sv
// Shared constants for the functional-unit writeback arbiter: source count,
// result width, tag widths and the fixed functional-unit index map.
package fu_wb_arb_pkg;

    localparam int NFU   = 5;
    localparam int XLEN  = 32;
    localparam int RD_W  = 5;
    localparam int SRC_W = 3;

    localparam int FU_ALU  = 0;
    localparam int FU_MEM  = 1;
    localparam int FU_MUL  = 2;
    localparam int FU_DIV  = 3;
    localparam int FU_JUMP = 4;

    // Width of an index into n sources; a single source still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester strictly after last_grant,
// wrapping back to index 0, so the last winner has the lowest priority.
module rr_arbiter #(
    parameter int N  = 5,
    parameter int IW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    // NOTE: every output gets a default before the search loops, so no path
    // through this block leaves a value unassigned and no latch is inferred.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!any && req[j] && (j > int'(last_grant))) begin
                any       = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IW'(j);
            end
        end
        // Wrapped half of the circular search: indices up to and including last_grant.
        for (int j = 0; j < N; j++) begin
            if (!any && req[j] && (j <= int'(last_grant))) begin
                any       = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/fu_wb_arb.sv
// Writeback arbiter: one holding buffer per functional unit, drained one
// result per cycle onto the register-file write port in round-robin order.
module fu_wb_arb #(
    parameter int NFU  = fu_wb_arb_pkg::NFU,
    parameter int XLEN = fu_wb_arb_pkg::XLEN
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NFU-1:0]                    fu_finish,
    input  logic [NFU*XLEN-1:0]               fu_res,
    input  logic [NFU*fu_wb_arb_pkg::RD_W-1:0] fu_rd,
    output logic                              wb_valid,
    output logic                              wb_we,
    output logic [fu_wb_arb_pkg::RD_W-1:0]    wb_rd,
    output logic [XLEN-1:0]                   wb_data,
    output logic [fu_wb_arb_pkg::SRC_W-1:0]   wb_src,
    output logic [NFU-1:0]                    fu_hold,
    output logic                              ovf_err
);

    import fu_wb_arb_pkg::*;

    localparam int IW = idx_w(NFU);

    logic [NFU-1:0]  valid_q, valid_d;
    logic [RD_W-1:0] rd_q   [NFU];
    logic [RD_W-1:0] rd_d   [NFU];
    logic [XLEN-1:0] data_q [NFU];
    logic [XLEN-1:0] data_d [NFU];
    logic [IW-1:0]   last_q, last_d;
    logic            ovf_q, ovf_d;

    logic [NFU-1:0]  grant;
    logic [IW-1:0]   grant_idx;
    logic            any;
    logic            retire;
    logic [NFU-1:0]  grant_eff;

    rr_arbiter #(
        .N  (NFU),
        .IW (IW)
    ) u_arb (
        .req        (valid_q),
        .last_grant (last_q),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .any        (any)
    );

    // Nothing retires while reset is held, even if stale entries are still valid.
    assign retire    = any & ~rst;
    assign grant_eff = grant & {NFU{~rst}};

    always_comb begin
        valid_d = valid_q;
        rd_d    = rd_q;
        data_d  = data_q;
        last_d  = last_q;
        ovf_d   = ovf_q;
        if (rst) begin
            valid_d = '0;
            for (int i = 0; i < NFU; i++) begin
                rd_d[i]   = '0;
                data_d[i] = '0;
            end
            last_d = IW'(NFU - 1);
            ovf_d  = 1'b0;
        end else begin
            for (int i = 0; i < NFU; i++) begin
                if (fu_finish[i]) begin
                    // A granted entry leaves this cycle, so the slot can take the new result.
                    if (!valid_q[i] || grant[i]) begin
                        valid_d[i] = 1'b1;
                        rd_d[i]    = fu_rd[RD_W*i +: RD_W];
                        data_d[i]  = fu_res[XLEN*i +: XLEN];
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else if (grant[i]) begin
                    valid_d[i] = 1'b0;
                end
            end
            if (any) begin
                last_d = grant_idx;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its next-state, independent of statement order.
    // NOTE: the rd/data arrays are reset along with the valid bits so that a
    // cleared buffer holds a defined zero payload rather than stale results.
    always_ff @(posedge clk) begin
        valid_q <= valid_d;
        rd_q    <= rd_d;
        data_q  <= data_d;
        last_q  <= last_d;
        ovf_q   <= ovf_d;
    end

    always_comb begin
        wb_rd   = '0;
        wb_data = '0;
        for (int i = 0; i < NFU; i++) begin
            if (grant_eff[i]) begin
                wb_rd   = wb_rd | rd_q[i];
                wb_data = wb_data | data_q[i];
            end
        end
    end

    assign wb_valid = retire;
    assign wb_we    = retire & (wb_rd != '0);
    assign wb_src   = retire ? SRC_W'(grant_idx) : '0;
    assign fu_hold  = rst ? '0 : valid_q;
    assign ovf_err  = ovf_q & ~rst;

endmodule

// File: tb/tb_fu_wb_arb.sv
// Scoreboard bench for fu_wb_arb: a queue-based reference model predicts each
// retirement; a negedge monitor compares DUT outputs against it every cycle.
module tb_fu_wb_arb;

    localparam int NFU  = fu_wb_arb_pkg::NFU;
    localparam int XLEN = fu_wb_arb_pkg::XLEN;

    typedef struct {
        int              src;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } exp_t;

    logic                clk;
    logic                rst;
    logic [NFU-1:0]      fu_finish;
    logic [NFU*XLEN-1:0] fu_res;
    logic [NFU*5-1:0]    fu_rd;
    logic                wb_valid;
    logic                wb_we;
    logic [4:0]          wb_rd;
    logic [XLEN-1:0]     wb_data;
    logic [2:0]          wb_src;
    logic [NFU-1:0]      fu_hold;
    logic                ovf_err;

    fu_wb_arb #(.NFU(NFU), .XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .fu_finish (fu_finish),
        .fu_res    (fu_res),
        .fu_rd     (fu_rd),
        .wb_valid  (wb_valid),
        .wb_we     (wb_we),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .wb_src    (wb_src),
        .fu_hold   (fu_hold),
        .ovf_err   (ovf_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: pending results per source plus the last winner.
    bit              m_valid [NFU];
    logic [4:0]      m_rd    [NFU];
    logic [XLEN-1:0] m_data  [NFU];
    int              m_last;
    bit              m_ovf;

    exp_t            exp_q[$];
    logic [NFU-1:0]  exp_hold;
    logic            exp_ovf;
    bit              mon_en;
    int              n_checks;
    int              n_fail;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic step(input logic r, input logic [NFU-1:0] fin,
                        input logic [NFU*XLEN-1:0] res, input logic [NFU*5-1:0] rdv);
        int pick;
        exp_t e;
        @(posedge clk);
        #1;
        rst       = r;
        fu_finish = fin;
        fu_res    = res;
        fu_rd     = rdv;
        if (r) begin
            exp_hold = '0;
            exp_ovf  = 1'b0;
            for (int i = 0; i < NFU; i++) begin
                m_valid[i] = 1'b0;
                m_rd[i]    = '0;
                m_data[i]  = '0;
            end
            m_last = NFU - 1;
            m_ovf  = 1'b0;
        end else begin
            pick = -1;
            for (int off = 1; off <= NFU; off++) begin
                if (pick < 0 && m_valid[(m_last + off) % NFU]) pick = (m_last + off) % NFU;
            end
            for (int i = 0; i < NFU; i++) exp_hold[i] = m_valid[i];
            exp_ovf = m_ovf;
            if (pick >= 0) begin
                e.src  = pick;
                e.rd   = m_rd[pick];
                e.data = m_data[pick];
                exp_q.push_back(e);
            end
            for (int i = 0; i < NFU; i++) begin
                if (fin[i]) begin
                    if (!m_valid[i] || i == pick) begin
                        m_valid[i] = 1'b1;
                        m_rd[i]    = rdv[i*5 +: 5];
                        m_data[i]  = res[i*XLEN +: XLEN];
                    end else begin
                        m_ovf = 1'b1;
                    end
                end else if (i == pick) begin
                    m_valid[i] = 1'b0;
                end
            end
            if (pick >= 0) m_last = pick;
        end
        mon_en = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, '0, '0, '0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            check("fu_hold", fu_hold, exp_hold);
            check("ovf_err", ovf_err, exp_ovf);
            check("wb_valid", wb_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (wb_valid) begin
                    check("wb_src", wb_src, e.src);
                    check("wb_rd", wb_rd, e.rd);
                    check("wb_data", wb_data, e.data);
                    check("wb_we", wb_we, e.rd != 0);
                end
            end else if (!wb_valid) begin
                check("idle_outputs", {wb_we, wb_src, wb_rd, wb_data}, '0);
            end
        end
    end

    initial begin
        logic [NFU*XLEN-1:0] r;
        logic [NFU*5-1:0]    d;
        n_checks  = 0;
        n_fail    = 0;
        mon_en    = 1'b0;
        rst       = 1'b1;
        fu_finish = '0;
        fu_res    = '0;
        fu_rd     = '0;
        step(1'b1, '0, '0, '0);
        step(1'b1, '0, '0, '0);

        // Single MUL completion.
        r = '0; d = '0;
        r[fu_wb_arb_pkg::FU_MUL*XLEN +: XLEN] = 32'h0000_0F00;
        d[fu_wb_arb_pkg::FU_MUL*5 +: 5]       = 5'd7;
        step(1'b0, 5'b00100, r, d);
        idle(3);

        // All-source burst straight after reset.
        step(1'b1, '0, '0, '0);
        for (int i = 0; i < NFU; i++) begin
            r[i*XLEN +: XLEN] = XLEN'(i + 1);
            d[i*5 +: 5]       = 5'(i + 1);
        end
        step(1'b0, 5'b11111, r, d);
        idle(NFU + 2);

        // Fairness: source 3 wins, then 1 and 4 become pending together.
        step(1'b1, '0, '0, '0);
        r = '0; d = '0;
        r[3*XLEN +: XLEN] = 32'h33; d[3*5 +: 5] = 5'd3;
        step(1'b0, 5'b01000, r, d);
        r = '0; d = '0;
        r[1*XLEN +: XLEN] = 32'h11; d[1*5 +: 5] = 5'd1;
        r[4*XLEN +: XLEN] = 32'h44; d[4*5 +: 5] = 5'd4;
        step(1'b0, 5'b10010, r, d);
        idle(4);

        // Overflow: source 0 granted while source 2 is refinished.
        step(1'b1, '0, '0, '0);
        r = '0; d = '0;
        r[0*XLEN +: XLEN] = 32'hA0; d[0*5 +: 5] = 5'd10;
        r[2*XLEN +: XLEN] = 32'hB2; d[2*5 +: 5] = 5'd12;
        step(1'b0, 5'b00101, r, d);
        r = '0; d = '0;
        r[2*XLEN +: XLEN] = 32'hC2; d[2*5 +: 5] = 5'd13;
        step(1'b0, 5'b00100, r, d);
        idle(4);

        // Drain and refill on source 1.
        step(1'b1, '0, '0, '0);
        r = '0; d = '0;
        r[1*XLEN +: XLEN] = 32'h1234_5678; d[1*5 +: 5] = 5'd9;
        step(1'b0, 5'b00010, r, d);
        r[1*XLEN +: XLEN] = 32'hDEAD_BEEF; d[1*5 +: 5] = 5'd21;
        step(1'b0, 5'b00010, r, d);
        idle(3);

        // rd=0 result, then reset with three entries pending, then a finish during reset.
        r = '0; d = '0;
        r[0*XLEN +: XLEN] = 32'h55;
        step(1'b0, 5'b00001, r, d);
        idle(2);
        for (int i = 0; i < NFU; i++) begin
            r[i*XLEN +: XLEN] = XLEN'(32'h100 + i);
            d[i*5 +: 5]       = 5'(20 + i);
        end
        step(1'b0, 5'b01110, r, d);
        step(1'b1, '0, '0, '0);
        idle(2);
        step(1'b1, 5'b11111, r, d);
        idle(2);

        // Randomised traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            logic [NFU-1:0] f;
            for (int i = 0; i < NFU; i++) begin
                f[i]              = ($urandom_range(0, 9) < 3);
                r[i*XLEN +: XLEN] = $urandom;
                d[i*5 +: 5]       = 5'($urandom_range(0, 31));
            end
            step($urandom_range(0, 59) == 0, f, r, d);
        end
        idle(NFU + 3);

        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fu_wb_arb.md
FU_WB_ARB -- requirements
Module: fu_wb_arb

Interface
REQ-001 The module SHALL expose parameter NFU, default 5, number of functional-unit sources (0 ALU, 1 MEM, 2 MUL, 3 DIV, 4 JUMP).
REQ-002 The module SHALL expose parameter XLEN, default 32, result width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 fu_finish  input  NFU  per-source completion pulse, valid for exactly the cycle the FU result is presented.
REQ-006 fu_res  input  NFU*XLEN  packed results; source i at bits [XLEN*i+XLEN-1 : XLEN*i].
REQ-007 fu_rd  input  NFU*5  packed destination register tags; source i at bits [5i+4 : 5i].
REQ-008 wb_valid  output  1  a completed result is retired this cycle.
REQ-009 wb_we  output  1  register-file write enable (wb_valid and wb_rd != 0).
REQ-010 wb_rd  output  5  destination register of the retired result.
REQ-011 wb_data  output  XLEN  retired result value.
REQ-012 wb_src  output  3  index of the source being retired.
REQ-013 fu_hold  output  NFU  per-source holding buffer occupied; issue logic SHALL NOT start a source whose bit is 1.
REQ-014 ovf_err  output  1  sticky: a completion was lost.

Function
REQ-015 Each source SHALL own a one-entry holding buffer {valid, rd, data}.
REQ-016 On fu_finish[i]=1, buffer i SHALL capture fu_res/fu_rd slice i at that edge; valid becomes 1 next cycle.
REQ-017 Minimum latency SHALL be one cycle: finish at cycle t, earliest wb_valid at t+1 with the captured data.
REQ-018 Each cycle at most one valid buffer SHALL be granted, round-robin: search starts at last_grant+1 modulo NFU.
REQ-019 wb_valid, wb_rd, wb_data, wb_src SHALL be combinational from the granted buffer; all zero when no buffer is valid.
REQ-020 last_grant SHALL update only in cycles with wb_valid=1.
REQ-021 A granted buffer SHALL clear at the end of its grant cycle.
REQ-022 fu_finish[i] while buffer i is valid and granted in the same cycle SHALL be accepted (drain and refill, valid stays 1).
REQ-023 fu_finish[i] while buffer i is valid and not granted SHALL drop the new result, keep the old entry, and set ovf_err.
REQ-024 fu_hold SHALL equal the buffer valid bits (registered, no combinational path from fu_finish).
REQ-025 A result with rd=0 SHALL still be retired (wb_valid=1, wb_we=0) so it frees its buffer.
REQ-026 Simultaneous finish on all NFU sources SHALL be accepted and retired over NFU consecutive cycles in round-robin order.

Reset
REQ-027 rst=1 SHALL clear all buffer valid bits, rd and data to 0, clear ovf_err, and set last_grant to NFU-1 (source 0 first priority).
REQ-028 During rst=1 all outputs SHALL be 0 and fu_finish SHALL be ignored; a completion pulse in a reset cycle is discarded without ovf_err.
REQ-029 Reset asserted mid-drain SHALL discard all pending entries; no retirement occurs in the reset cycle.

Structure
REQ-030 A shared package SHALL hold NFU, XLEN, and the FU index constants (FU_ALU=0, FU_MEM=1, FU_MUL=2, FU_DIV=3, FU_JUMP=4).
REQ-031 The round-robin grant logic SHALL be a separate sub-module rr_arbiter (inputs req[NFU], last_grant; outputs grant one-hot, grant_idx, any).

Verification
REQ-032 Single MUL completion: fu_finish=5'b00100, res slice2=32'h0000_0F00, rd slice2=7 at t -> t+1 wb_valid=1, wb_we=1, wb_rd=7, wb_data=32'h0000_0F00, wb_src=2; t+2 wb_valid=0, fu_hold=0.
REQ-033 All-source burst after reset: fu_finish=5'b11111, data i = i+1, rd i = i+1 -> wb_src 0,1,2,3,4 on five consecutive cycles with data 1..5, then idle; ovf_err=0.
REQ-034 Round-robin fairness: after source 3 granted, sources 1 and 4 pending -> source 4 granted before source 1.
REQ-035 Overflow: sources 0 and 2 pending, source 0 granted, second finish on source 2 same cycle -> source 2 keeps first value, ovf_err=1 and stays 1 until rst.
REQ-036 Drain-and-refill: source 1 sole pending (granted) with new finish data 32'hDEAD_BEEF same cycle -> next cycle wb_data=32'hDEAD_BEEF, ovf_err=0.
REQ-037 rd=0 and reset mid-drain: rd=0 result -> wb_valid=1, wb_we=0; rst asserted with 3 entries pending -> all outputs 0 next cycle, fu_hold=0.
